ex_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage pipeline around the execute stage.
- Generates ALU operand forwarding selects, load-use stalls with a single bubble, and flushes on a taken branch resolved in MEM.
- Provides a global freeze for external memory wait.
- Sits beside the pipeline registers and drives the PC, IF/ID, ID/EX and EX/MEM write, flush and bubble controls.
- Keeps saturating stall and flush event counters for debug.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/fwd_unit.sv | 25 ++
 rtl/ex_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the execute-stage hazard controller: FSM states and
// forwarding-select encodings.
package pipe_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/fwd_unit.sv
// Combinational ALU operand forwarding select for one source register.
// EX/MEM takes priority over MEM/WB; register 0 never forwards.
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int unsigned REG_W = pipe_pkg::REG_W
) (
  input  logic [REG_W-1:0] ex_src,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] wb_dst,
  input  logic             wb_regwrite,
  output logic [1:0]       sel
);

  always_comb begin
    sel = FWD_RF;
    if (mem_regwrite && (mem_dst != '0) && (mem_dst == ex_src)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite && (wb_dst != '0) && (wb_dst == ex_src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Hazard and sequencing controller around EX: forwarding, load-use bubble,
// branch flush in MEM, external freeze and saturating debug event counters.
module ex_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_W = pipe_pkg::REG_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] wb_dst,
  input  logic             wb_regwrite,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             ext_stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             pipe_en,
  output logic             idex_bubble,
  output logic             pc_src,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;
  logic [1:0]       sel_a, sel_b;
  logic             br_taken, lu_haz;

  fwd_unit #(.REG_W(REG_W)) u_fwd_a (
    .ex_src       (ex_rs),
    .mem_dst      (mem_dst),
    .mem_regwrite (mem_regwrite),
    .wb_dst       (wb_dst),
    .wb_regwrite  (wb_regwrite),
    .sel          (sel_a)
  );

  fwd_unit #(.REG_W(REG_W)) u_fwd_b (
    .ex_src       (ex_rt),
    .mem_dst      (mem_dst),
    .mem_regwrite (mem_regwrite),
    .wb_dst       (wb_dst),
    .wb_regwrite  (wb_regwrite),
    .sel          (sel_b)
  );

  assign br_taken = mem_branch & mem_zero;
  assign lu_haz   = ex_memread & (ex_dst != '0) & ((ex_dst == id_rs) | (ex_dst == id_rt));

  always_comb begin
    fwd_a       = sel_a;
    fwd_b       = sel_b;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    pipe_en     = 1'b1;
    idex_bubble = 1'b0;
    pc_src      = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    state_d     = state_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    if (!reset) begin
      // Keep the pipeline quiescent while reset is held.
      fwd_a      = FWD_RF;
      fwd_b      = FWD_RF;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_en    = 1'b0;
      state_d    = StRun;
    end else if (ext_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_en    = 1'b0;
      stall_inc  = 1'b1;
    end else if (br_taken) begin
      pc_src      = 1'b1;
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
      flush_inc   = 1'b1;
      state_d     = StFlush;
    end else begin
      unique case (state_q)
        StRun: begin
          if (lu_haz) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
            state_d     = StStall;
          end
        end
        StStall: state_d = StRun;
        StFlush: state_d = StRun;
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign state       = state_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed-vector bench for ex_hazard_ctrl with hand-computed expectations.
module tb_ex_hazard_ctrl;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [REG_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
  logic             ex_memread, mem_regwrite, wb_regwrite, mem_branch, mem_zero, ext_stall;
  logic [1:0]       fwd_a, fwd_b, state;
  logic             pc_write, ifid_write, pipe_en, idex_bubble, pc_src;
  logic             flush_ifid, flush_idex, flush_exmem;
  logic [CNT_W-1:0] stall_count, flush_count;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  ex_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_dst       (ex_dst),
    .ex_memread   (ex_memread),
    .mem_dst      (mem_dst),
    .mem_regwrite (mem_regwrite),
    .wb_dst       (wb_dst),
    .wb_regwrite  (wb_regwrite),
    .mem_branch   (mem_branch),
    .mem_zero     (mem_zero),
    .ext_stall    (ext_stall),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .pipe_en      (pipe_en),
    .idex_bubble  (idex_bubble),
    .pc_src       (pc_src),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .flush_exmem  (flush_exmem),
    .state        (state),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_dst = '0;
    mem_dst = '0; wb_dst = '0;
    ex_memread = 0; mem_regwrite = 0; wb_regwrite = 0;
    mem_branch = 0; mem_zero = 0; ext_stall = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    #1 reset = 1'b0;
    // Forwarding hazard present during reset must not show through.
    mem_dst = 5'd5; ex_rs = 5'd5; mem_regwrite = 1;
    #1;
    chk("rst_state", state, 0);
    chk("rst_stall_cnt", stall_count, 0);
    chk("rst_flush_cnt", flush_count, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_pipe_en", pipe_en, 0);
    chk("rst_fwd_a", fwd_a, 2'b00);
    tick();
    reset = 1'b1;
    tick();

    // Forwarding priority
    mem_dst = 5'd5; wb_dst = 5'd5; ex_rs = 5'd5; mem_regwrite = 1; wb_regwrite = 1;
    #1;
    chk("fwd_a_mem_prio", fwd_a, 2'b10);
    chk("fwd_b_none", fwd_b, 2'b00);
    chk("dflt_pc_write", pc_write, 1);
    chk("dflt_pipe_en", pipe_en, 1);
    mem_regwrite = 0;
    #1 chk("fwd_a_wb", fwd_a, 2'b01);
    ex_rs = 0; mem_dst = 0; mem_regwrite = 1; wb_dst = 0;
    #1 chk("fwd_a_r0", fwd_a, 2'b00);
    ex_rt = 5'd7; wb_dst = 5'd7;
    #1 chk("fwd_b_wb", fwd_b, 2'b01);
    clear_inputs();

    // Register 0 load never stalls
    ex_memread = 1; ex_dst = 0; id_rs = 0;
    #1 chk("lu_r0_no_stall", pc_write, 1);

    // Load-use, held: stall, STALL, stall again (back-to-back)
    ex_dst = 5'd8; id_rt = 5'd8;
    #1;
    chk("lu_pc_write", pc_write, 0);
    chk("lu_ifid_write", ifid_write, 0);
    chk("lu_bubble", idex_bubble, 1);
    chk("lu_pipe_en", pipe_en, 1);
    tick();
    chk("lu_state_stall", state, 1);
    chk("lu_stall_cnt1", stall_count, 1);
    chk("stall_dflt_pc_write", pc_write, 1);
    chk("stall_dflt_bubble", idex_bubble, 0);
    tick();
    chk("lu_state_run", state, 0);
    chk("lu_again_bubble", idex_bubble, 1);
    tick();
    chk("lu_stall_cnt2", stall_count, 2);
    ex_memread = 0;
    tick();
    chk("lu_back_run", state, 0);

    // Taken branch overrides simultaneous load-use
    ex_memread = 1; ex_dst = 5'd8; id_rt = 5'd8; mem_branch = 1; mem_zero = 1;
    #1;
    chk("br_pc_src", pc_src, 1);
    chk("br_flush_ifid", flush_ifid, 1);
    chk("br_flush_idex", flush_idex, 1);
    chk("br_flush_exmem", flush_exmem, 1);
    chk("br_no_bubble", idex_bubble, 0);
    chk("br_pc_write", pc_write, 1);
    tick();
    chk("br_state_flush", state, 2);
    chk("br_flush_cnt", flush_count, 1);
    mem_zero = 0;
    #1;
    chk("nt_pc_src", pc_src, 0);
    chk("nt_flush", flush_idex, 0);
    chk("flush_no_bubble", idex_bubble, 0);
    tick();
    chk("flush_to_run", state, 0);
    chk("nt_flush_cnt", flush_count, 1);
    clear_inputs();

    // Freeze with branch pending
    ext_stall = 1; mem_branch = 1; mem_zero = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_pipe_en", pipe_en, 0);
      chk("frz_pc_src", pc_src, 0);
      tick();
    end
    chk("frz_stall_cnt", stall_count, 5);
    chk("frz_state", state, 0);
    ext_stall = 0;
    #1 chk("frz_then_pc_src", pc_src, 1);
    tick();
    chk("frz_flush_cnt", flush_count, 2);
    clear_inputs();
    tick();

    // Async reset mid-STALL
    ex_memread = 1; ex_dst = 5'd9; id_rs = 5'd9;
    tick();
    chk("pre_rst_state", state, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_stall_cnt", stall_count, 0);
    chk("mid_rst_flush_cnt", flush_count, 0);
    chk("mid_rst_pc_write", pc_write, 0);
    #1 reset = 1'b1;
    #1 chk("post_rst_bubble", idex_bubble, 1);
    tick();
    chk("post_rst_state", state, 1);
    chk("post_rst_stall_cnt", stall_count, 1);
    clear_inputs();

    // Saturation: 65538 more freeze cycles from 1
    ext_stall = 1;
    repeat ((1 << CNT_W) + 2) @(posedge clk);
    #1;
    chk("sat_stall_cnt", stall_count, 16'hFFFF);
    chk("sat_flush_cnt", flush_count, 0);
    ext_stall = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
